// File: rtl/event_ingress_mux.sv
// Round-robin event ingress multiplexer with POR sequencer, FWFT output FIFO and activity LED stretcher.
// Optional per-source accept counters are compiled in when EVENT_INGRESS_STATS_EN is defined.
module event_ingress_mux #(
  parameter int NUM_SRC        = 2,
  parameter int DATA_W         = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int POR_CYCLES     = 32,
  parameter int STRETCH_CYCLES = 600000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC-1:0]        src_enable,
  output logic [DATA_W-1:0]         evt_data,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic                      core_rst_n,
  output logic                      led_activity,
  output logic [NUM_SRC*16-1:0]     accept_count
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int QW = $clog2(POR_CYCLES + 1);
  localparam int SW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;

  localparam logic [QW-1:0] POR_MAX  = QW'(POR_CYCLES);
  localparam logic [SW-1:0] ST_LOAD  = SW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_SRC = PW'(NUM_SRC - 1);

  logic [QW-1:0]     r_por_cnt;
  logic [PW-1:0]     r_rr;
  logic [SW-1:0]     r_st;
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

  logic              w_core_ok;
  logic              w_full;
  logic              w_found;
  logic [PW-1:0]     w_gnt;
  logic [PW-1:0]     w_idx;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_words [NUM_SRC];
  logic [DATA_W-1:0] w_push_data;

  // POR counter: counts up from 0 after rst_n release and holds at POR_CYCLES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_por_cnt <= '0;
    end else if (r_por_cnt != POR_MAX) begin
      r_por_cnt <= r_por_cnt + QW'(1);
    end else begin
      r_por_cnt <= r_por_cnt;
    end
  end

  assign w_core_ok  = (r_por_cnt == POR_MAX);
  assign core_rst_n = w_core_ok;
  assign w_full     = (r_cnt == FULL_CNT);
  assign evt_valid  = (r_cnt != '0);

  // Round-robin search starting at r_rr for the first valid and enabled source
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = PW'((int'(r_rr) + k) % NUM_SRC);
      if (!w_found && src_valid[w_idx] && src_enable[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end else begin
        w_found = w_found;
        w_gnt   = w_gnt;
      end
    end
  end

  // Ready only toward the granted source, and never while the core is held or the FIFO is full
  always_comb begin
    src_ready = '0;
    if (w_core_ok && w_found && !w_full) begin
      src_ready[w_gnt] = 1'b1;
    end else begin
      src_ready = '0;
    end
  end

  // Unpack the flat source bus so the granted word can be selected by index
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_words[i] = src_data[i*DATA_W +: DATA_W];
    end
  end

  assign w_push_data = w_words[w_gnt];
  assign w_push      = |(src_valid & src_ready);
  assign w_pop       = evt_valid & evt_ready;
  assign evt_data    = evt_valid ? r_mem[r_rd] : '0;

  // Output FIFO storage, pointers and occupancy; push is already blocked at full by src_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_push_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Round-robin pointer moves just past the source that completed a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (w_push) begin
      r_rr <= (w_gnt == LAST_SRC) ? '0 : (w_gnt + PW'(1));
    end else begin
      r_rr <= r_rr;
    end
  end

  // Activity stretcher: reload on accept, then count down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st <= '0;
    end else if (w_push) begin
      r_st <= ST_LOAD;
    end else if (r_st != '0) begin
      r_st <= r_st - SW'(1);
    end else begin
      r_st <= r_st;
    end
  end

  assign led_activity = w_push | (r_st != '0);

`ifdef EVENT_INGRESS_STATS_EN
  logic [15:0] r_acc [NUM_SRC];

  // Saturating per-source accept counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_acc[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && src_ready[i] && (r_acc[i] != 16'hFFFF)) begin
          r_acc[i] <= r_acc[i] + 16'd1;
        end
      end
    end
  end

  // Pack counters onto the flat output bus
  always_comb begin
    accept_count = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      accept_count[i*16 +: 16] = r_acc[i];
    end
  end
`else
  assign accept_count = '0;
`endif

endmodule

// File: tb/tb_event_ingress_mux.sv
// Directed bench for event_ingress_mux: a queue-based reference model checked every cycle,
// plus hand-computed expectations for POR timing, arbitration order, fill/drain, masking, stats and reset.
module tb_event_ingress_mux;
  localparam int NS    = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int POR   = 32;
  localparam int STR   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]    src_valid;
  logic [NS-1:0]    src_ready;
  logic [NS-1:0]    src_enable;
  logic [DW-1:0]    evt_data;
  logic             evt_valid;
  logic             evt_ready;
  logic             core_rst_n;
  logic             led_activity;
  logic [NS*16-1:0] accept_count;

  event_ingress_mux #(
    .NUM_SRC(NS), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .POR_CYCLES(POR), .STRETCH_CYCLES(STR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .src_enable(src_enable), .evt_data(evt_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .core_rst_n(core_rst_n),
    .led_activity(led_activity), .accept_count(accept_count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  logic [DW-1:0] m_q [$];
  int            m_por;
  int            m_rr;
  int            m_st;
  int            m_cnt [NS];
  int            hs_log [$];
  logic [DW-1:0] out_log [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_por = 0;
    m_rr  = 0;
    m_st  = 0;
    for (int i = 0; i < NS; i++) m_cnt[i] = 0;
  endtask

  // Reference model: evaluate expected outputs at the falling edge, then advance to the next rising edge
  always @(negedge clk) begin
    int            g;
    int            idx;
    bit            fnd;
    bit            e_core;
    bit            e_hs;
    logic [NS-1:0] e_rdy;
    logic [31:0]   e_ac;
    logic [DW-1:0] e_data;
    if (!rst_n) model_reset();
    e_core = (m_por == POR);
    fnd = 1'b0;
    g = 0;
    for (int k = 0; k < NS; k++) begin
      idx = (m_rr + k) % NS;
      if (!fnd && src_valid[idx] && src_enable[idx]) begin
        fnd = 1'b1;
        g = idx;
      end
    end
    e_rdy = '0;
    if (e_core && fnd && m_q.size() < DEPTH) e_rdy[g] = 1'b1;
    e_hs = |(e_rdy & src_valid);
    e_data = (m_q.size() > 0) ? m_q[0] : 32'd0;
`ifdef EVENT_INGRESS_STATS_EN
    e_ac = {m_cnt[1][15:0], m_cnt[0][15:0]};
`else
    e_ac = 32'd0;
`endif
    check("src_ready", {62'd0, src_ready}, {62'd0, e_rdy});
    check("evt_valid", {63'd0, evt_valid}, {63'd0, m_q.size() > 0});
    check("evt_data", {32'd0, evt_data}, {32'd0, e_data});
    check("core_rst_n", {63'd0, core_rst_n}, {63'd0, e_core});
    check("led_activity", {63'd0, led_activity}, {63'd0, (e_hs || m_st != 0)});
    check("accept_count", {32'd0, accept_count}, {32'd0, e_ac});
    for (int i = 0; i < NS; i++) if (src_valid[i] && src_ready[i]) hs_log.push_back(i);
    if (evt_valid && evt_ready) out_log.push_back(evt_data);
    if (rst_n) begin
      if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
      if (e_hs) begin
        m_q.push_back(src_data[g*DW +: DW]);
        m_rr = (g + 1) % NS;
        if (m_cnt[g] < 65535) m_cnt[g]++;
        m_st = STR - 1;
      end else if (m_st > 0) begin
        m_st--;
      end
      if (m_por < POR) m_por++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(output logic [NS-1:0] sr);
    @(negedge clk);
    sr = src_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int  n;
    bit  rdy_seen;
    rst_n      = 1'b0;
    src_valid  = 2'b11;
    src_enable = 2'b11;
    evt_ready  = 1'b0;
    src_data   = {32'hB000_0000, 32'hA000_0000};
    repeat (3) tick();
    rst_n = 1'b1;
    n = 0;
    rdy_seen = 1'b0;
    while (!core_rst_n && n < 100) begin
      if (src_ready != 2'b00) rdy_seen = 1'b1;
      tick();
      n++;
    end
    check("por_cycles", 64'(n), 64'(POR));
    check("ready_during_por", {63'd0, rdy_seen}, 64'd0);
    src_valid = 2'b00;
  endtask

  initial begin
    logic [NS-1:0] sr;
    int word;
    int nacc;
    int guard;
    int nb;
    int nled;
    bit r1_seen;

    rst_n = 1'b0;
    src_valid = '0;
    src_enable = '0;
    evt_ready = 1'b0;
    src_data = '0;
    #2;
    check("rst_core_rst_n", {63'd0, core_rst_n}, 64'd0);
    check("rst_evt_valid", {63'd0, evt_valid}, 64'd0);

    // Round robin
    do_reset();
    hs_log.delete();
    src_data = {32'hB000_0001, 32'hA000_0001};
    src_valid = 2'b11;
    evt_ready = 1'b1;
    repeat (8) step(sr);
    src_valid = 2'b00;
    repeat (3) tick();
    check("rr_count", 64'(hs_log.size()), 64'd8);
    if (hs_log.size() >= 4) begin
      check("rr_0", 64'(hs_log[0]), 64'd0);
      check("rr_1", 64'(hs_log[1]), 64'd1);
      check("rr_2", 64'(hs_log[2]), 64'd0);
      check("rr_3", 64'(hs_log[3]), 64'd1);
    end

    // Fill then drain
    do_reset();
    src_enable = 2'b01;
    src_valid = 2'b01;
    evt_ready = 1'b0;
    word = 1;
    nacc = 0;
    for (int c = 0; c < 12; c++) begin
      src_data[31:0] = 32'(word);
      step(sr);
      if (sr[0]) begin word++; nacc++; end
    end
    src_data[31:0] = 32'(word);
    #1;
    check("fill_accepts", 64'(nacc), 64'd8);
    check("fill_ready_low", {63'd0, src_ready[0]}, 64'd0);
    out_log.delete();
    evt_ready = 1'b1;
    guard = 0;
    while (word <= 10 && guard < 40) begin
      src_data[31:0] = 32'(word);
      step(sr);
      if (sr[0]) word++;
      guard++;
    end
    src_valid = 2'b00;
    repeat (12) tick();
    check("drain_count", 64'(out_log.size()), 64'd10);
    for (int i = 0; i < 10 && i < out_log.size(); i++)
      check("drain_order", {32'd0, out_log[i]}, 64'(i + 1));

    // Masking
    do_reset();
    out_log.delete();
    src_enable = 2'b01;
    src_valid = 2'b11;
    src_data = {32'hB000_0001, 32'hA000_0001};
    evt_ready = 1'b1;
    r1_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(sr);
      if (sr[1]) r1_seen = 1'b1;
    end
    src_valid = 2'b00;
    repeat (3) tick();
    nb = 0;
    foreach (out_log[i]) if (out_log[i][31:28] == 4'hB) nb++;
    check("mask_ready1", {63'd0, r1_seen}, 64'd0);
    check("mask_src1_words", 64'(nb), 64'd0);
    check("mask_src0_rate", 64'(out_log.size()), 64'd10);

    // Stats and LED stretch
    do_reset();
    src_enable = 2'b10;
    src_valid = 2'b10;
    src_data = {32'hC000_0000, 32'h0};
    evt_ready = 1'b1;
    nacc = 0;
    guard = 0;
    while (nacc < 3 && guard < 20) begin
      step(sr);
      if (sr[1]) nacc++;
      guard++;
    end
    src_valid = 2'b00;
`ifdef EVENT_INGRESS_STATS_EN
    check("stats_count", {32'd0, accept_count}, 64'h0003_0000);
`else
    check("stats_count", {32'd0, accept_count}, 64'd0);
`endif
    nled = 0;
    repeat (8) begin
      @(negedge clk);
      if (led_activity) nled++;
    end
    check("led_stretch", 64'(nled), 64'(STR - 1));
    tick();

    // Mid-run reset discards queued words
    do_reset();
    src_enable = 2'b01;
    src_valid = 2'b01;
    src_data = {32'h0, 32'hD000_0000};
    evt_ready = 1'b0;
    nacc = 0;
    guard = 0;
    while (nacc < 5 && guard < 20) begin
      step(sr);
      if (sr[0]) nacc++;
      guard++;
    end
    src_valid = 2'b00;
    tick();
    check("mid_queued", {63'd0, evt_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_evt_valid", {63'd0, evt_valid}, 64'd0);
    check("mid_rst_core", {63'd0, core_rst_n}, 64'd0);
    out_log.delete();
    do_reset();
    evt_ready = 1'b1;
    repeat (20) tick();
    check("mid_nothing_out", 64'(out_log.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/event_ingress_mux.md
EVENT_INGRESS_MUX -- requirements
Module: event_ingress_mux

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, number of event sources (1..8).
REQ-002 SHALL have parameter DATA_W, default 32, event word width (EVT2 word).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, output FIFO entries (power of 2, 2..64).
REQ-004 SHALL have parameter POR_CYCLES, default 32, cycles core reset is held after rst_n deasserts (1..1024).
REQ-005 SHALL have parameter STRETCH_CYCLES, default 600000, activity LED hold time in cycles (1 or more).
REQ-006 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port src_data, input, NUM_SRC*DATA_W, source i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port src_valid, input, NUM_SRC, per-source valid.
REQ-010 SHALL have port src_ready, output, NUM_SRC, per-source ready.
REQ-011 SHALL have port src_enable, input, NUM_SRC, per-source enable mask.
REQ-012 SHALL have port evt_data, output, DATA_W, FIFO head word.
REQ-013 SHALL have port evt_valid, output, 1, FIFO non-empty.
REQ-014 SHALL have port evt_ready, input, 1, downstream accepts head.
REQ-015 SHALL have port core_rst_n, output, 1, active-low reset for downstream core.
REQ-016 SHALL have port led_activity, output, 1, stretched event-accept indicator.
REQ-017 SHALL have port accept_count, output, NUM_SRC*16, per-source accepted-event counters.

Function
REQ-018 SHALL run a POR counter from 0 after rst_n deasserts; core_rst_n = 0 until the counter reaches POR_CYCLES, then 1 and counter holds.
REQ-019 SHALL drive src_ready all 0, and accept nothing, while core_rst_n = 0.
REQ-020 SHALL grant at most one source per cycle: first i with src_valid[i] & src_enable[i], searching from rr_ptr upward modulo NUM_SRC.
REQ-021 SHALL assert src_ready[i] only for the granted source, only when FIFO not full; handshake = src_valid[i] & src_ready[i].
REQ-022 SHALL on a handshake from source g set rr_ptr to (g+1) mod NUM_SRC; rr_ptr unchanged otherwise.
REQ-023 SHALL keep src_ready[i] = 0 for any source with src_enable[i] = 0, regardless of valid.
REQ-024 SHALL be first-word-fall-through: accepted word visible on evt_data with evt_valid = 1 on the cycle after handshake when FIFO was empty (latency 1).
REQ-025 SHALL pop on evt_valid & evt_ready; evt_data SHALL stay stable while evt_valid & !evt_ready.
REQ-026 SHALL refuse push when full, even if a pop occurs in the same cycle (no push-through at full).
REQ-027 SHALL on simultaneous push and pop with FIFO non-empty and non-full leave occupancy unchanged, preserving order.
REQ-028 SHALL wrap read/write pointers modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-029 SHALL reload the stretch counter to STRETCH_CYCLES-1 on each handshake and decrement to 0 otherwise; led_activity = 1 while handshake this cycle or counter non-zero.
REQ-030 SHALL with one source enabled and continuously valid sustain one accept per cycle while FIFO has space.

Reset
REQ-031 SHALL on rst_n = 0 immediately (asynchronously) force: core_rst_n = 0, src_ready = 0, evt_valid = 0, evt_data = 0, led_activity = 0, accept_count = 0, rr_ptr = 0, FIFO empty, POR counter = 0.
REQ-032 SHALL on reset mid-operation discard all FIFO contents; restart POR sequence on deassertion.
REQ-033 SHALL rely on no initial values; all state is reset via rst_n.

Configuration
REQ-034 SHALL under macro EVENT_INGRESS_STATS_EN defined keep per-source 16-bit counters that increment on each handshake and saturate at 0xFFFF.
REQ-035 SHALL without EVENT_INGRESS_STATS_EN keep accept_count port, driven constant 0, with no counter logic.

Verification
REQ-036 SHALL pass POR: release rst_n, POR_CYCLES=32 -> core_rst_n rises exactly 32 cycles later; src_ready = 0 before.
REQ-037 SHALL pass round-robin: NUM_SRC=2, both valid continuously, evt_ready=1 -> accepts alternate 0,1,0,1; each src handshakes every other cycle.
REQ-038 SHALL pass fill/drain: evt_ready=0, src0 pushes 0x00000001..0x0000000A, depth 8 -> 8 accepted, src_ready falls when full; evt_ready=1 -> 0x01..0x08 out in order, then 0x09,0x0A accepted.
REQ-039 SHALL pass masking: src_enable=2'b01, both valid -> src_ready[1] stays 0, only src0 words appear.
REQ-040 SHALL pass mid-run reset: rst_n low with 5 entries queued -> evt_valid = 0 same cycle, nothing emerges after POR.
REQ-041 SHALL pass stats: STATS_EN defined, 3 accepts from src1 -> accept_count[31:16] = 3, [15:0] = 0; undefined -> all 0.
